c880_bist_ctrl: RTL and testbench
=================================

// Module: c880_bist_ctrl
// PURPOSE
//   Logic-BIST harness for the c880 ALU benchmark. It is the response end of the
//   c880 interface: it drives all 60 primary inputs and compacts all 26 primary outputs.
//   An LFSR generates pseudo-random patterns on cut_pi. A MISR folds cut_po into a
//   26-bit signature. An FSM sequences NUM_PATTERNS captures and compares the result
//   against golden_sig. The c880 netlist sits outside this block, wired cut_pi -> CUT -> cut_po.
// PARAMETERS
//   PI_W          60      CUT input width (LFSR width; the polynomial below is fixed for 60)
//   PO_W          26      CUT output width (MISR width; the polynomial below is fixed for 26)
//   NUM_PATTERNS  1024    patterns applied per run, range 1..2^CNT_W-1
//   CNT_W         16      pattern counter width
//   LFSR_SEED     60'h1   LFSR load value; a value of 0 is replaced by 1
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request a run; sampled in IDLE and DONE only
//   hold         in   1      freeze LFSR, MISR and counter while in RUN
//   golden_sig   in   26     expected signature; sampled on entry to DONE
//   cut_pi       out  60     pattern to the CUT; always equals the LFSR register
//   cut_po       in   26     CUT response; combinational from cut_pi
//   busy         out  1      1 while in RUN
//   done         out  1      1 while in DONE
//   pass         out  1      signature == golden_sig; valid only while done=1
//   signature    out  26     MISR register contents
//   pattern_cnt  out  CNT_W  number of captures completed in the current run
// BEHAVIOUR
//   Reset values:
//     state=IDLE, cut_pi=LFSR_SEED, signature=0, pattern_cnt=0, busy=0, done=0, pass=0.
//   LFSR (Fibonacci, x^60+x^59+1):
//     lfsr <= {lfsr[58:0], lfsr[59]^lfsr[58]}
//   MISR (x^26+x^6+x^2+x+1):
//     fb    = m[25]^m[5]^m[1]^m[0]
//     m    <= {m[24:0], fb} ^ cut_po
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     - start=1 -> RUN; at the same edge load lfsr=LFSR_SEED, m=0, cnt=0.
//   RUN, on each edge with hold=0:
//     - MISR absorbs the cut_po produced by the current cut_pi.
//     - LFSR advances, and cnt increments.
//     - The capture that brings cnt to NUM_PATTERNS moves the FSM to DONE.
//   RUN, on an edge with hold=1:
//     - LFSR, MISR, counter and state are all unchanged.
//     - hold has no effect outside RUN.
//   DONE:
//     - pass is registered on entry as (m_next == golden_sig).
//     - signature, pass and cut_pi hold their values.
//     - start=1 -> RUN with the same reload as from IDLE (back-to-back runs allowed).
//   start while in RUN is ignored; a run cannot be restarted without reset.
//   Latency: with start sampled at edge E0 and hold=0 throughout, captures occur at
//     edges E1..EN (N=NUM_PATTERNS). done=1 and busy=0 from EN onward.
//   No combinational path from any input to any output. cut_pi, busy, done, pass
//     and signature are all registered.
//   rst_n asserted mid-run: immediate return to the reset values; no partial pass/done.
//   NUM_PATTERNS=1: a single capture at E1, then DONE.
// TESTING
//   1. Reset: with rst_n=0, cut_pi=60'h1, signature=0, busy=0, done=0, pass=0;
//      these values persist after release with start=0.
//   2. NUM_PATTERNS=4, SEED=1, CUT stub po=pi[25:0], golden=26'h6:
//      - cut_pi sequence is 1,2,4,8;
//      - signature steps 1,1,7,6;
//      - done=1 and pass=1 at E4.
//   3. Same setup as 2 with golden=26'h7 -> done=1 and pass=0 at E4, signature=26'h6.
//   4. Same setup as 2 with hold=1 for 3 cycles after E2:
//      - pattern_cnt stays at 2 and cut_pi stays at 4 during the hold;
//      - done is delayed by 3 cycles; final signature is still 26'h6.
//   5. Same setup as 2:
//      - pulse start again at E2 -> ignored, run ends at E4 as normal;
//      - start in DONE -> second run reproduces signature 26'h6.
//   6. Same setup as 2 with rst_n low at E2 -> all reset values, done never asserts;
//      a new start then completes normally with pass=1.

Source files
------------

// File: rtl/c880_bist_if.sv
// Bundle between the c880 BIST controller and its environment: run control,
// CUT pattern/response and result reporting.
interface c880_bist_if #(
    parameter int unsigned PI_W  = 60,
    parameter int unsigned PO_W  = 26,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             hold;
    logic [PO_W-1:0]  golden_sig;
    logic [PI_W-1:0]  cut_pi;
    logic [PO_W-1:0]  cut_po;
    logic             busy;
    logic             done;
    logic             pass;
    logic [PO_W-1:0]  signature;
    logic [CNT_W-1:0] pattern_cnt;

    // Master: the environment, including the CUT that closes cut_pi -> cut_po.
    modport master (
        output start, hold, golden_sig, cut_po,
        input  cut_pi, busy, done, pass, signature, pattern_cnt
    );

    modport slave (
        input  start, hold, golden_sig, cut_po,
        output cut_pi, busy, done, pass, signature, pattern_cnt
    );
endinterface

// File: rtl/c880_bist_ctrl.sv
// Logic-BIST controller for the c880 benchmark: LFSR pattern source, MISR response
// compactor and a run sequencer that compares the final signature to a golden value.
module c880_bist_ctrl #(
    parameter int unsigned     PI_W         = 60,
    parameter int unsigned     PO_W         = 26,
    parameter int unsigned     NUM_PATTERNS = 1024,
    parameter int unsigned     CNT_W        = 16,
    parameter logic [PI_W-1:0] LFSR_SEED    = 60'h1
) (
    input  logic       clk,
    input  logic       rst_n,
    c880_bist_if.slave bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [PI_W-1:0] SeedEff = (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;

    logic [1:0]       state_q, state_d;
    logic [PI_W-1:0]  lfsr_q, lfsr_d;
    logic [PO_W-1:0]  misr_q, misr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             busy_q, done_q;

    logic [PO_W-1:0]  misr_next;
    logic [PI_W-1:0]  lfsr_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             misr_fb;
    logic             last_capture;

    always_comb begin
        misr_fb      = misr_q[PO_W-1] ^ misr_q[5] ^ misr_q[1] ^ misr_q[0];
        misr_next    = {misr_q[PO_W-2:0], misr_fb} ^ bus.cut_po;
        lfsr_next    = {lfsr_q[PI_W-2:0], lfsr_q[PI_W-1] ^ lfsr_q[PI_W-2]};
        cnt_inc      = cnt_q + CNT_W'(1);
        last_capture = (cnt_inc == CNT_W'(NUM_PATTERNS));
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    lfsr_d  = SeedEff;
                    misr_d  = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            StRun: begin
                if (!bus.hold) begin
                    misr_d = misr_next;
                    lfsr_d = lfsr_next;
                    cnt_d  = cnt_inc;
                    if (last_capture) begin
                        state_d = StDone;
                        pass_d  = (misr_next == bus.golden_sig);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lfsr_q  <= SeedEff;
            misr_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            // Status flags get their own flops so they carry no decode logic.
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    assign bus.cut_pi      = lfsr_q;
    assign bus.signature   = misr_q;
    assign bus.pattern_cnt = cnt_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;

endmodule

// File: tb/tb_c880_bist_ctrl.sv
// Bench for c880_bist_ctrl: two instances (4 patterns, and 1 pattern with a zero seed)
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_c880_bist_ctrl;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic        hold   = 1'b0;
    logic [25:0] gold_a = 26'h0;
    logic [25:0] gold_b = 26'h0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    c880_bist_if ia ();
    c880_bist_if ib ();

    assign ia.start      = start;
    assign ia.hold       = hold;
    assign ia.golden_sig = gold_a;
    assign ib.start      = start;
    assign ib.hold       = hold;
    assign ib.golden_sig = gold_b;

    // CUT stubs standing in for the c880 netlist.
    assign ia.cut_po = ia.cut_pi[25:0];
    assign ib.cut_po = ib.cut_pi[25:0] ^ {ib.cut_pi[0], ib.cut_pi[59:35]};

    c880_bist_ctrl #(.NUM_PATTERNS(4), .LFSR_SEED(60'h1)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave)
    );

    c880_bist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(60'h0)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int np_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [59:0] seed_of(input int d);
        logic [59:0] raw;
        raw = (d == 0) ? 60'h1 : 60'h0;
        return (raw == 60'h0) ? 60'h1 : raw;
    endfunction

    // Pattern presented after k LFSR advances from the seed.
    function automatic logic [59:0] pi_after(input int d, input int k);
        logic [59:0] v;
        v = seed_of(d);
        for (int i = 0; i < k; i++) v = {v[58:0], v[59] ^ v[58]};
        return v;
    endfunction

    function automatic logic [25:0] cut(input int d, input logic [59:0] pi);
        if (d == 0) return pi[25:0];
        return pi[25:0] ^ {pi[0], pi[59:35]};
    endfunction

    function automatic logic [25:0] fold(input logic [25:0] s, input logic [25:0] po);
        return {s[24:0], s[25] ^ s[5] ^ s[1] ^ s[0]} ^ po;
    endfunction

    bit          m_run  [2] = '{default: 1'b0};
    bit          m_fin  [2] = '{default: 1'b0};
    bit          m_pass [2] = '{default: 1'b0};
    int          m_k    [2] = '{default: 0};
    logic [25:0] m_sig  [2] = '{default: 26'h0};

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_run[d] = 1'b0; m_fin[d] = 1'b0; m_pass[d] = 1'b0;
                m_k[d] = 0; m_sig[d] = 26'h0;
            end else if (!m_run[d]) begin
                if (start) begin
                    m_run[d] = 1'b1; m_fin[d] = 1'b0; m_pass[d] = 1'b0;
                    m_k[d] = 0; m_sig[d] = 26'h0;
                end
            end else if (!hold) begin
                m_sig[d] = fold(m_sig[d], cut(d, pi_after(d, m_k[d])));
                m_k[d]++;
                if (m_k[d] == np_of(d)) begin
                    m_run[d]  = 1'b0;
                    m_fin[d]  = 1'b1;
                    m_pass[d] = (m_sig[d] == ((d == 0) ? gold_a : gold_b));
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("a.cut_pi",      ia.cut_pi,      pi_after(0, m_k[0]));
        chk("a.signature",   ia.signature,   m_sig[0]);
        chk("a.pattern_cnt", ia.pattern_cnt, 64'(m_k[0]));
        chk("a.busy",        ia.busy,        m_run[0]);
        chk("a.done",        ia.done,        m_fin[0]);
        chk("a.pass",        ia.pass,        m_pass[0]);
        chk("b.cut_pi",      ib.cut_pi,      pi_after(1, m_k[1]));
        chk("b.signature",   ib.signature,   m_sig[1]);
        chk("b.pattern_cnt", ib.pattern_cnt, 64'(m_k[1]));
        chk("b.busy",        ib.busy,        m_run[1]);
        chk("b.done",        ib.done,        m_fin[1]);
        chk("b.pass",        ib.pass,        m_pass[1]);
    end

    // ---------------- stimulus and literal expectations ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, " cut_pi"}, ia.cut_pi, 60'h1);
        chk({tag, " signature"}, ia.signature, 26'h0);
        chk({tag, " busy"}, ia.busy, 1'b0);
        chk({tag, " done"}, ia.done, 1'b0);
        chk({tag, " pass"}, ia.pass, 1'b0);
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [59:0] exp_pi  [4] = '{60'h1, 60'h2, 60'h4, 60'h8};
    logic [25:0] exp_sig [4] = '{26'h1, 26'h1, 26'h7, 26'h6};

    initial begin
        #1 rst_n = 1'b0;
        gold_a = 26'h6;
        gold_b = 26'h2000001;
        repeat (3) tick();
        chk_reset_a("t1 in reset");
        rst_n = 1'b1;
        repeat (3) tick();
        chk_reset_a("t1 after release");

        // Test 2: pattern sequence, signature steps, pass on golden match.
        launch();
        for (int i = 0; i < 4; i++) begin
            chk("t2 cut_pi", ia.cut_pi, exp_pi[i]);
            tick();
            chk("t2 signature", ia.signature, exp_sig[i]);
            if (i == 0) begin
                chk("t2 b.done", ib.done, 1'b1);
                chk("t2 b.signature", ib.signature, 26'h2000001);
                chk("t2 b.pass", ib.pass, 1'b1);
                chk("t2 b.cut_pi", ib.cut_pi, 60'h2);
            end
            if (i < 3) chk("t2 done early", ia.done, 1'b0);
        end
        chk("t2 done", ia.done, 1'b1);
        chk("t2 pass", ia.pass, 1'b1);
        chk("t2 busy", ia.busy, 1'b0);

        // Test 3: golden mismatch; restart from DONE.
        gold_a = 26'h7;
        launch();
        repeat (4) tick();
        chk("t3 done", ia.done, 1'b1);
        chk("t3 pass", ia.pass, 1'b0);
        chk("t3 signature", ia.signature, 26'h6);

        // Test 4: hold for three cycles after E2.
        gold_a = 26'h6;
        launch();
        repeat (2) tick();
        chk("t4 cnt at E2", ia.pattern_cnt, 16'd2);
        hold = 1'b1;
        repeat (3) begin
            tick();
            chk("t4 hold cnt", ia.pattern_cnt, 16'd2);
            chk("t4 hold cut_pi", ia.cut_pi, 60'h4);
            chk("t4 hold done", ia.done, 1'b0);
        end
        hold = 1'b0;
        tick();
        chk("t4 done early", ia.done, 1'b0);
        tick();
        chk("t4 done", ia.done, 1'b1);
        chk("t4 signature", ia.signature, 26'h6);
        chk("t4 pass", ia.pass, 1'b1);

        // Test 5: start during RUN ignored; back-to-back run from DONE.
        launch();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5 done early", ia.done, 1'b0);
        tick();
        chk("t5 done", ia.done, 1'b1);
        chk("t5 cnt", ia.pattern_cnt, 16'd4);
        chk("t5 signature", ia.signature, 26'h6);
        launch();
        chk("t5 rerun busy", ia.busy, 1'b1);
        repeat (4) tick();
        chk("t5 rerun signature", ia.signature, 26'h6);
        chk("t5 rerun pass", ia.pass, 1'b1);

        // Test 6: reset mid-run, then a clean run.
        launch();
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_a("t6 mid-run reset");
        chk("t6 cnt", ia.pattern_cnt, 16'd0);
        repeat (5) begin
            tick();
            chk("t6 done in reset", ia.done, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        launch();
        repeat (4) tick();
        chk("t6 done", ia.done, 1'b1);
        chk("t6 pass", ia.pass, 1'b1);

        // Randomized phase, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            start  = ($urandom_range(0, 3) == 0);
            hold   = ($urandom_range(0, 2) == 0);
            rst_n  = ($urandom_range(0, 199) != 0);
            gold_a = ($urandom_range(0, 1) == 1) ? 26'h6 : 26'($urandom);
            gold_b = ($urandom_range(0, 1) == 1) ? 26'h2000001 : 26'($urandom);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
